uart_tx_multi: RTL and testbench

UART_TX_MULTI -- requirements
Module: uart_tx_multi

---
 rtl/uart_pkg.sv | 50 +++++
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_tx_multi.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_multi.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the multi-format UART transmitter: FSM states, parity and stop encodings.
// Pure declarations plus small combinational helpers; no latency of its own.
// No flow control here; users decide how the helpers feed their pipelines.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_ODD   = 3'd1;
  localparam logic [2:0] PAR_EVEN  = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  localparam logic [1:0] STOP_1   = 2'd0;
  localparam logic [1:0] STOP_1P5 = 2'd1;
  localparam logic [1:0] STOP_2   = 2'd2;

  // Shortest legal bit period in clocks; smaller programmed divisors are raised to this.
  localparam int MIN_DIV = 4;

  // Parity codes above SPACE are reserved and behave as NONE.
  function automatic logic parity_enabled(input logic [2:0] par);
    return (par >= PAR_ODD) && (par <= PAR_SPACE);
  endfunction

  // Parity bit over the active data bits only (5..8 LSBs of the word).
  function automatic logic parity_bit(input logic [2:0] par, input logic [1:0] dbits,
                                      input logic [7:0] data);
    logic [7:0] mask;
    logic       x;
    mask = 8'hFF >> (2'd3 - dbits);
    x    = ^(data & mask);
    case (par)
      PAR_ODD:   return ~x;
      PAR_EVEN:  return x;
      PAR_MARK:  return 1'b1;
      PAR_SPACE: return 1'b0;
      PAR_NONE:  return 1'b0;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
// Write-to-read latency 1 cycle (entry visible on rd_data the cycle after the push).
// Pushes while full are dropped without touching contents; pops while empty are ignored.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_multi.sv
// UART transmitter with FIFO, runtime divisor, 5..8 data bits, parity, 1/1.5/2 stop bits and break.
// Latency: word pushed into an empty idle block at cycle T pulls the line low from cycle T+2.
// tdata_ready drops while the FIFO is full; frames run back-to-back while words are queued.
module uart_tx_multi
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int BAUD         = 115200,
  parameter int FIFO_DEPTH   = 16,
  parameter int DIV_W        = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DIV_W-1:0]              cfg_baud_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [2:0]                    cfg_parity,
  input  logic [1:0]                    cfg_stop_bits,
  input  logic                          cfg_break,
  input  logic [7:0]                    tdata,
  input  logic                          tdata_valid,
  output logic                          tdata_ready,
  output logic                          uart_tx,
  output logic                          uart_tx_is_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_done
);

  // One extra bit so a 2x divisor (longest stop time, post-break guard) never wraps.
  localparam int CNT_W = DIV_W + 1;
  localparam longint DIV_RST_RAW = (longint'(CLK_FREQ_MHZ) * 64'd1000000) / longint'(BAUD);
  localparam logic [DIV_W-1:0] DIV_RST =
    (DIV_RST_RAW < longint'(MIN_DIV)) ? DIV_W'(MIN_DIV) : DIV_W'(DIV_RST_RAW);

  uart_state_t      state;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       dbits_q;
  logic [1:0]       stop_q;
  logic             par_en_q;
  logic             par_bit_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] guard;

  logic [DIV_W-1:0] eff_div;
  logic [CNT_W-1:0] bit_len;
  logic [CNT_W-1:0] stop_len;
  logic             bit_end;
  logic             stop_end;
  logic             pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (tdata_valid),
    .wr_data (tdata),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign eff_div         = (cfg_baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_baud_div;
  assign bit_len         = {1'b0, div_q};
  assign bit_end         = (cnt == bit_len - CNT_W'(1));
  assign stop_end        = (cnt == stop_len - CNT_W'(1));
  assign tdata_ready     = !fifo_full;
  assign uart_tx_is_busy = (state != IDLE) || !fifo_empty;

  // Stop time in clocks from the divisor latched at frame start.
  always_comb begin
    stop_len = bit_len;
    case (stop_q)
      STOP_1:   stop_len = bit_len;
      STOP_1P5: stop_len = bit_len + CNT_W'(div_q >> 1);
      STOP_2:   stop_len = {div_q, 1'b0};
      default:  stop_len = {div_q, 1'b0};
    endcase
  end

  // A new frame starts (and pops its word) from IDLE after the break guard, or straight out of STOP.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !cfg_break && (guard == '0) && !fifo_empty;
      STOP:    pop = stop_end && !cfg_break && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // Frame sequencer; uart_tx and tx_done are registered, a frame start overrides the state step.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      uart_tx   <= 1'b1;
      tx_done   <= 1'b0;
      div_q     <= DIV_RST;
      dbits_q   <= 2'd3;
      stop_q    <= STOP_1;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      shift_q   <= '0;
      bit_idx   <= '0;
      cnt       <= '0;
      guard     <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_break) begin
            state   <= BREAK;
            uart_tx <= 1'b0;
          end else if (guard != '0) begin
            guard <= guard - CNT_W'(1);
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
            uart_tx <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == ({1'b0, dbits_q} + 3'd4)) begin
              if (par_en_q) begin
                state   <= PARITY;
                uart_tx <= par_bit_q;
              end else begin
                state   <= STOP;
                uart_tx <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            cnt     <= '0;
            uart_tx <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (stop_end) begin
            state   <= IDLE;
            cnt     <= '0;
            tx_done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        BREAK: begin
          if (!cfg_break) begin
            state   <= IDLE;
            uart_tx <= 1'b1;
            guard   <= {div_q, 1'b0};
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
      if (pop) begin
        state     <= START;
        uart_tx   <= 1'b0;
        cnt       <= '0;
        div_q     <= eff_div;
        dbits_q   <= cfg_data_bits;
        stop_q    <= cfg_stop_bits;
        par_en_q  <= parity_enabled(cfg_parity);
        par_bit_q <= parity_bit(cfg_parity, cfg_data_bits, fifo_dout);
        shift_q   <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_multi.sv
// Self-checking bench: cycle-exact line model built from frame waveforms, directed and random stimulus.
// Inputs are driven on the falling edge; outputs are compared on the falling edge.
// Every bounded wait that expires is reported as a failed comparison.
`timescale 1ns/1ps
module tb_uart_tx_multi;

  localparam int DEPTH   = 4;
  localparam int DIV_RST = 868;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] cfg_baud_div;
  logic [1:0]  cfg_data_bits;
  logic [2:0]  cfg_parity;
  logic [1:0]  cfg_stop_bits;
  logic        cfg_break;
  logic [7:0]  tdata;
  logic        tdata_valid;
  logic        tdata_ready;
  logic        uart_tx;
  logic        uart_tx_is_busy;
  logic [2:0]  fifo_level;
  logic        tx_done;

  always #5 clk = ~clk;

  uart_tx_multi #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .rstn(rstn), .cfg_baud_div(cfg_baud_div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop_bits(cfg_stop_bits), .cfg_break(cfg_break),
    .tdata(tdata), .tdata_valid(tdata_valid), .tdata_ready(tdata_ready), .uart_tx(uart_tx),
    .uart_tx_is_busy(uart_tx_is_busy), .fifo_level(fifo_level), .tx_done(tx_done)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of words and per-clock line waveform ----------------
  logic [7:0] mq[$];
  bit         wave[$];
  bit         in_frame, in_brk;
  int         guard_m, m_div;
  bit         exp_tx, exp_done, exp_busy, exp_ready;
  int         exp_level;

  task automatic start_frame();
    int d, nb, ones, sl;
    logic [7:0] w;
    bit p, pen;
    d     = (cfg_baud_div < 16'd4) ? 4 : int'(cfg_baud_div);
    m_div = d;
    w     = mq.pop_front();
    nb    = 5 + int'(cfg_data_bits);
    ones  = 0;
    for (int i = 0; i < nb; i++) ones += int'(w[i]);
    pen = (cfg_parity >= 3'd1) && (cfg_parity <= 3'd4);
    case (cfg_parity)
      3'd1:    p = (ones % 2 == 0);
      3'd2:    p = (ones % 2 == 1);
      3'd3:    p = 1'b1;
      default: p = 1'b0;
    endcase
    sl = (cfg_stop_bits == 2'd0) ? d : (cfg_stop_bits == 2'd1) ? d + d / 2 : 2 * d;
    repeat (d) wave.push_back(1'b0);
    for (int i = 0; i < nb; i++) repeat (d) wave.push_back(w[i]);
    if (pen) repeat (d) wave.push_back(p);
    repeat (sl) wave.push_back(1'b1);
    exp_tx   = wave.pop_front();
    in_frame = 1'b1;
  endtask

  // Advance the model by one clock using the inputs the DUT samples on this edge.
  always @(posedge clk) begin
    bit can_push;
    can_push = (mq.size() < DEPTH);
    exp_done = 1'b0;
    if (!rstn) begin
      mq.delete();
      wave.delete();
      in_frame = 1'b0;
      in_brk   = 1'b0;
      guard_m  = 0;
      m_div    = DIV_RST;
      exp_tx   = 1'b1;
    end else begin
      if (wave.size() > 0) begin
        exp_tx = wave.pop_front();
      end else if (in_frame) begin
        exp_done = 1'b1;
        in_frame = 1'b0;
        if (mq.size() > 0 && !cfg_break) start_frame();
        else exp_tx = 1'b1;
      end else if (in_brk) begin
        if (!cfg_break) begin
          in_brk  = 1'b0;
          guard_m = 2 * m_div;
          exp_tx  = 1'b1;
        end else begin
          exp_tx = 1'b0;
        end
      end else if (cfg_break) begin
        in_brk = 1'b1;
        exp_tx = 1'b0;
      end else if (guard_m > 0) begin
        guard_m--;
        exp_tx = 1'b1;
      end else if (mq.size() > 0) begin
        start_frame();
      end else begin
        exp_tx = 1'b1;
      end
      if (tdata_valid && can_push) mq.push_back(tdata);
    end
    exp_level = mq.size();
    exp_busy  = in_frame || in_brk || (mq.size() > 0);
    exp_ready = (mq.size() < DEPTH);
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("uart_tx", uart_tx, exp_tx);
      check("tx_done", tx_done, exp_done);
      check("fifo_level", fifo_level, exp_level);
      check("tdata_ready", tdata_ready, exp_ready);
      check("busy", uart_tx_is_busy, exp_busy);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic cap  [0:255];
  logic capd [0:255];

  task automatic set_cfg(input int div, input int db, input int par, input int sb);
    cfg_baud_div  = 16'(div);
    cfg_data_bits = 2'(db);
    cfg_parity    = 3'(par);
    cfg_stop_bits = 2'(sb);
  endtask

  task automatic push1(input logic [7:0] w);
    @(negedge clk);
    tdata       = w;
    tdata_valid = 1'b1;
  endtask

  task automatic idle1();
    @(negedge clk);
    tdata_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      cap[i]  = uart_tx;
      capd[i] = tx_done;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = !uart_tx_is_busy;
    end
    check(name, seen, 1'b1);
    repeat (40) @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = tx_done;
    end
    check(name, seen, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    int cntv, frames, lows, highs, brk_left;
    bit stop_hi;
    rstn = 1'b0;
    set_cfg(4, 3, 0, 0);
    cfg_break   = 1'b0;
    tdata       = 8'h00;
    tdata_valid = 1'b0;
    repeat (3) @(negedge clk);
    rstn   = 1'b1;
    chk_en = 1'b1;
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_level", fifo_level, 3'd0);
    check("rst_ready", tdata_ready, 1'b1);
    check("rst_busy", uart_tx_is_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);

    // 8N1 at div 4, 0x55: line still high at T+1, then start and LSB-first bits.
    push1(8'h55);
    idle1();
    check("8n1_t1_high", uart_tx, 1'b1);
    @(negedge clk);
    capture(41);
    v = '0;
    for (int i = 0; i < 40; i++) v[i] = cap[i];
    check("8n1_wave", v, 64'h00000000F0F0F0F0F0);
    v = '0;
    for (int i = 0; i < 40; i++) v[0] = v[0] | capd[i];
    check("8n1_early_done", v, 64'd0);
    check("8n1_done", capd[40], 1'b1);
    wait_idle("8n1_idle", 200);

    // 7E2 at div 8, 0x03 then 0x07 back to back.
    set_cfg(8, 2, 2, 2);
    push1(8'h03);
    push1(8'h07);
    idle1();
    capture(176);
    check("7e2_d0", cap[12], 1'b1);
    check("7e2_d2", cap[28], 1'b0);
    check("7e2_par1", cap[68], 1'b0);
    cntv = 0;
    for (int i = 72; i < 88; i++) cntv += int'(cap[i]);
    check("7e2_stop_len", cntv, 16);
    check("7e2_back2back", {cap[87], cap[88]}, 2'b10);
    check("7e2_par2", cap[156], 1'b1);
    wait_idle("7e2_idle", 400);

    // 5O1.5 at div 6, 0xFF.
    set_cfg(6, 0, 1, 1);
    push1(8'hFF);
    idle1();
    @(negedge clk);
    capture(60);
    cntv = 0;
    for (int i = 6; i < 36; i++) cntv += int'(cap[i]);
    check("5o15_data", cntv, 30);
    check("5o15_par", cap[38], 1'b0);
    stop_hi = 1'b1;
    for (int i = 42; i < 51; i++) stop_hi &= cap[i];
    check("5o15_stop", stop_hi, 1'b1);
    check("5o15_done", {capd[50], capd[51]}, 2'b01);
    wait_idle("5o15_idle", 200);

    // Overfill while busy: four entries kept, extra pushes dropped.
    set_cfg(5, 3, 0, 0);
    push1(8'hA0);
    for (int i = 1; i <= 6; i++) push1(8'(8'hA0 + i));
    idle1();
    check("full_level", fifo_level, 3'd4);
    check("full_ready", tdata_ready, 1'b0);
    frames = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_done) frames++;
      if (!uart_tx_is_busy) break;
    end
    check("full_frames", frames, 5);
    wait_idle("full_idle", 100);

    // Break raised mid-frame: frame finishes, line held low, queued word waits for the guard.
    set_cfg(6, 3, 0, 0);
    push1(8'h11);
    push1(8'h22);
    idle1();
    repeat (30) @(negedge clk);
    cfg_break = 1'b1;
    wait_done("brk_frame_done", 200);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lows += int'(!uart_tx);
    end
    cfg_break = 1'b0;
    check("brk_low", lows, 100);
    check("brk_no_pop", fifo_level, 3'd1);
    highs = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!uart_tx) break;
      highs++;
    end
    check("brk_guard", highs >= 12, 1'b1);
    wait_done("brk_next_frame", 200);
    wait_idle("brk_idle", 200);

    // Randomized traffic, configuration changes and short breaks.
    brk_left = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      tdata_valid = ($urandom_range(0, 5) == 0);
      tdata       = 8'($urandom);
      if ($urandom_range(0, 60) == 0)
        set_cfg($urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3));
      if (brk_left > 0) begin
        brk_left--;
        if (brk_left == 0) cfg_break = 1'b0;
      end else if ($urandom_range(0, 1999) == 0) begin
        cfg_break = 1'b1;
        brk_left  = $urandom_range(5, 60);
      end
    end
    @(negedge clk);
    tdata_valid = 1'b0;
    cfg_break   = 1'b0;
    wait_idle("rand_idle", 5000);

    // Reset during DATA with three words queued.
    set_cfg(8, 3, 0, 0);
    push1(8'h01);
    push1(8'h02);
    push1(8'h03);
    push1(8'h04);
    idle1();
    repeat (15) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("rst_mid_tx", uart_tx, 1'b1);
    check("rst_mid_level", fifo_level, 3'd0);
    check("rst_mid_busy", uart_tx_is_busy, 1'b0);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lows += int'(!uart_tx);
    end
    check("rst_no_frames", lows, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
